// File: rtl/mem_sweep_scheduler.sv
// mem_sweep_scheduler: arbitrates one memory port between a host and a sweep
// engine, sequences classification sweeps, and tallies/logs the engine's
// per-address error samples.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start / busy / done      sweep request level, sweep in progress, results stable
//   host_*                   host access: req/we/addr/din in, gnt/rvalid/rdata out
//   sw_*                     sweep engine: sw_start out, write/read/classify inputs in
//   mem_*                    single memory port (1-cycle synchronous read)
//   cnt_high / cnt_both      counts of type 01 / type 10 samples
//   log_count / log_ovf      valid error-log entries, log overflow flag
//   log_rd_en/idx/data       registered error-log read port
module mem_sweep_scheduler #(
    parameter int unsigned N_WORDS   = 1 << 20,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = $clog2(N_WORDS),
    parameter int unsigned LOG_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         host_req,
    input  logic                         host_we,
    input  logic [ADDR_W-1:0]            host_addr,
    input  logic [DATA_W-1:0]            host_din,
    output logic                         host_gnt,
    output logic                         host_rvalid,
    output logic [DATA_W-1:0]            host_rdata,
    output logic                         sw_start,
    input  logic                         sw_we,
    input  logic [ADDR_W-1:0]            sw_addr,
    input  logic [DATA_W-1:0]            sw_din,
    input  logic                         sw_read_phase,
    input  logic [ADDR_W-1:0]            sw_addr_out,
    input  logic [1:0]                   sw_error_type,
    input  logic                         sw_all_done,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_din,
    input  logic [DATA_W-1:0]            mem_dout,
    output logic [ADDR_W:0]              cnt_high,
    output logic [ADDR_W:0]              cnt_both,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_ovf,
    input  logic                         log_rd_en,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
    output logic [ADDR_W+1:0]            log_rd_data
);

    localparam int unsigned LOG_W = $clog2(LOG_DEPTH);
    localparam int unsigned ENT_W = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t state, state_next;
    logic   busy_next, done_next, sw_start_next;

    logic              s_v;
    logic [ADDR_W-1:0] s_a;
    logic [ENT_W-1:0]  log_mem [LOG_DEPTH];

    logic sweep_entry_c;
    logic hit_c;
    logic log_full_c;

    // State register plus registered state-decoded outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sw_start <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= busy_next;
            done     <= done_next;
            sw_start <= sw_start_next;
        end
    end

    // Next state and next-cycle output decode
    always_comb begin
        state_next    = state;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        sw_start_next = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_next = SWEEP;
            SWEEP:      if (sw_all_done) state_next = DRAIN;
            DRAIN:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
        case (state_next)
            SWEEP: begin
                busy_next     = 1'b1;
                sw_start_next = 1'b1;
            end
            DRAIN:   busy_next = 1'b1;
            DONE:    done_next = 1'b1;
            default: ;
        endcase
    end

    // busy mirrors state in {SWEEP, DRAIN}; start beats the host for the port
    assign sweep_entry_c = !busy && start;
    assign host_gnt      = host_req && !rst && !busy && !start;

    // Memory port ownership
    assign mem_we   = busy ? sw_we   : (host_we && host_gnt);
    assign mem_addr = busy ? sw_addr : host_addr;
    assign mem_din  = busy ? sw_din  : host_din;

    // Read data returns one cycle after a granted host read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) host_rvalid <= 1'b0;
        else     host_rvalid <= host_gnt && !host_we;
    end
    assign host_rdata = mem_dout;

    // Align engine read phase/address with the 1-cycle memory latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_v <= 1'b0;
            s_a <= '0;
        end else begin
            s_v <= sw_read_phase;
            s_a <= sw_addr_out;
        end
    end

    assign hit_c      = busy && s_v && (sw_error_type == 2'b01 || sw_error_type == 2'b10);
    assign log_full_c = (log_count >= (LOG_W + 1)'(LOG_DEPTH));

    // Error counters and log bookkeeping, cleared on sweep entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_high  <= '0;
            cnt_both  <= '0;
            log_count <= '0;
            log_ovf   <= 1'b0;
        end else if (sweep_entry_c) begin
            cnt_high  <= '0;
            cnt_both  <= '0;
            log_count <= '0;
            log_ovf   <= 1'b0;
        end else if (hit_c) begin
            if (sw_error_type == 2'b01) cnt_high <= cnt_high + (ADDR_W + 1)'(1);
            else                        cnt_both <= cnt_both + (ADDR_W + 1)'(1);
            if (!log_full_c) log_count <= log_count + (LOG_W + 1)'(1);
            else             log_ovf   <= 1'b1;
        end
    end

    // Log storage keeps its contents across reset
    always_ff @(posedge clk) begin
        if (hit_c && !log_full_c) log_mem[log_count[LOG_W-1:0]] <= {sw_error_type, s_a};
    end

    // Registered log read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            log_rd_data <= '0;
        else if (log_rd_en) log_rd_data <= log_mem[log_rd_idx];
    end

endmodule

// File: tb/tb_mem_sweep_scheduler.sv
// tb_mem_sweep_scheduler: drives mem_sweep_scheduler (N_WORDS=8, LOG_DEPTH=4)
// with a write-0-then-read sweep engine model and a memory model with stuck
// words; table-driven fault scenarios plus hand-written corner sequences.
module tb_mem_sweep_scheduler;

    localparam int unsigned N_WORDS   = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned LOG_DEPTH = 4;

    logic              clk, rst, start, busy, done;
    logic              host_req, host_we, host_gnt, host_rvalid;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_din, host_rdata;
    logic              sw_start, sw_we, sw_read_phase, sw_all_done;
    logic [ADDR_W-1:0] sw_addr, sw_addr_out;
    logic [DATA_W-1:0] sw_din;
    logic [1:0]        sw_error_type;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic [ADDR_W:0]   cnt_high, cnt_both;
    logic [2:0]        log_count;
    logic              log_ovf, log_rd_en;
    logic [1:0]        log_rd_idx;
    logic [ADDR_W+1:0] log_rd_data;

    mem_sweep_scheduler #(
        .N_WORDS(N_WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .sw_start(sw_start), .sw_we(sw_we), .sw_addr(sw_addr), .sw_din(sw_din),
        .sw_read_phase(sw_read_phase), .sw_addr_out(sw_addr_out),
        .sw_error_type(sw_error_type), .sw_all_done(sw_all_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .cnt_high(cnt_high), .cnt_both(cnt_both), .log_count(log_count), .log_ovf(log_ovf),
        .log_rd_en(log_rd_en), .log_rd_idx(log_rd_idx), .log_rd_data(log_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: 8 write cycles of 0, then 8 read cycles
    logic [3:0] eng_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                eng_cnt <= '0;
        else if (!sw_start)     eng_cnt <= '0;
        else if (eng_cnt != 15) eng_cnt <= eng_cnt + 4'd1;
    end
    assign sw_we         = sw_start && !eng_cnt[3];
    assign sw_addr       = eng_cnt[2:0];
    assign sw_din        = '0;
    assign sw_read_phase = sw_start && eng_cnt[3];
    assign sw_addr_out   = eng_cnt[2:0];
    assign sw_all_done   = sw_start && (eng_cnt == 4'd15);

    // Classifier: high byte only -> 01, both bytes -> 10, low byte only -> 11
    always_comb begin
        sw_error_type = 2'b00;
        if (|mem_dout[15:8] && |mem_dout[7:0]) sw_error_type = 2'b10;
        else if (|mem_dout[15:8])              sw_error_type = 2'b01;
        else if (|mem_dout[7:0])               sw_error_type = 2'b11;
    end

    // Memory model with per-word stuck values
    logic [DATA_W-1:0]        mem [N_WORDS];
    logic [7:0]               stuck_en;
    logic [7:0][DATA_W-1:0]   stuck_val;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= stuck_en[mem_addr] ? stuck_val[mem_addr] : mem[mem_addr];
    end

    typedef struct packed {
        logic [7:0]           en;
        logic [7:0][15:0]     val;
        logic [3:0]           high;
        logic [3:0]           both;
        logic [2:0]           lcnt;
        logic                 ovf;
        logic [3:0][4:0]      lg;
    } vec_t;

    vec_t              vecs [5];
    vec_t              sb [$];
    logic [15:0]       host_sb [$];
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input vec_t v);
        stuck_en  = v.en;
        stuck_val = v.val;
    endtask

    task automatic read_log(input int idx, output logic [4:0] d);
        log_rd_en  = 1'b1;
        log_rd_idx = 2'(idx);
        @(negedge clk);
        log_rd_en  = 1'b0;
        d = log_rd_data;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sw_start"}, sw_start, 0);
        chk({tag, "_host_gnt"}, host_gnt, 0);
        chk({tag, "_host_rvalid"}, host_rvalid, 0);
        chk({tag, "_counts"}, {cnt_high, cnt_both, log_count, log_ovf}, 0);
        chk({tag, "_log_rd_data"}, log_rd_data, 0);
    endtask

    // Counts sweep cycles from base until done; optionally pokes start mid-sweep
    task automatic wait_done(input int base, input bit mid, output int cyc, output bit ok);
        cyc = base;
        ok  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mid) start = (cyc >= 12 && cyc <= 13);
            @(negedge clk);
            if (sw_start) cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (mid) start = 1'b0;
    endtask

    // Pop the expected sweep result and compare counters and log contents
    task automatic check_results(input bit read_entries);
        vec_t e;
        logic [4:0] d;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=empty required=entry");
            return;
        end
        e = sb.pop_front();
        chk("cnt_high", cnt_high, e.high);
        chk("cnt_both", cnt_both, e.both);
        chk("log_count", log_count, e.lcnt);
        chk("log_ovf", log_ovf, e.ovf);
        if (read_entries) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(e.lcnt)) begin
                    read_log(i, d);
                    chk($sformatf("log_entry%0d", i), d, e.lg[i]);
                end
            end
        end
    endtask

    task automatic run_sweep(input vec_t v, input bit mid, input bit host_clash);
        int cyc;
        bit ok;
        load_mem(v);
        sb.push_back(v);
        @(negedge clk);
        start = 1'b1;
        if (host_clash) begin
            host_req  = 1'b1;
            host_we   = 1'b0;
            host_addr = 3'd5;
            #1;
            chk("host_gnt_vs_start", host_gnt, 0);
        end
        @(negedge clk);
        start    = 1'b0;
        host_req = 1'b0;
        chk("busy_on_entry", busy, 1);
        chk("sw_start_on_entry", sw_start, 1);
        chk("clear_on_entry", {cnt_high, cnt_both, log_count, log_ovf}, 0);
        if (host_clash) chk("host_rvalid_after_clash", host_rvalid, 0);
        wait_done(1, mid, cyc, ok);
        chk("done_reached", ok, 1);
        chk("sweep_cycles", cyc, 16);
        chk("busy_in_done", busy, 0);
        check_results(1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        bit         ok;
        vec_t       e;
        logic [15:0] hx;

        // Fault scenarios: {stuck words, expected counts, expected log}
        vecs[0] = '0;
        vecs[1] = '0;
        vecs[1].en[3] = 1'b1; vecs[1].val[3] = 16'h0100;
        vecs[1].en[7] = 1'b1; vecs[1].val[7] = 16'h0101;
        vecs[1].high = 4'd1; vecs[1].both = 4'd1; vecs[1].lcnt = 3'd2;
        vecs[1].lg[0] = {2'b01, 3'd3}; vecs[1].lg[1] = {2'b10, 3'd7};
        vecs[2] = '0;
        vecs[2].en = 8'b0111_0111;
        for (int i = 0; i < 8; i++) vecs[2].val[i] = 16'h0200;
        vecs[2].high = 4'd6; vecs[2].lcnt = 3'd4; vecs[2].ovf = 1'b1;
        vecs[2].lg[0] = {2'b01, 3'd0}; vecs[2].lg[1] = {2'b01, 3'd1};
        vecs[2].lg[2] = {2'b01, 3'd2}; vecs[2].lg[3] = {2'b01, 3'd4};
        vecs[3] = '0;
        vecs[3].en[1] = 1'b1; vecs[3].val[1] = 16'h0001;
        vecs[3].en[2] = 1'b1; vecs[3].val[2] = 16'h0001;
        vecs[3].en[6] = 1'b1; vecs[3].val[6] = 16'h8000;
        vecs[3].high = 4'd1; vecs[3].lcnt = 3'd1; vecs[3].lg[0] = {2'b01, 3'd6};
        vecs[4] = '0;
        vecs[4].en = 8'b1010_0101;
        for (int i = 0; i < 8; i++) vecs[4].val[i] = 16'h0303;
        vecs[4].both = 4'd4; vecs[4].lcnt = 3'd4;
        vecs[4].lg[0] = {2'b10, 3'd0}; vecs[4].lg[1] = {2'b10, 3'd2};
        vecs[4].lg[2] = {2'b10, 3'd5}; vecs[4].lg[3] = {2'b10, 3'd7};

        rst = 1'b1; start = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 3'd5; host_din = '0;
        log_rd_en = 1'b0; log_rd_idx = '0;
        load_mem(vecs[0]);
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        host_req = 1'b0;

        // Start beats a same-cycle host read; clean sweep
        run_sweep(vecs[0], 1'b0, 1'b1);

        // Table of fault scenarios; vector 2 also pokes start mid-sweep
        for (int i = 0; i < 5; i++) run_sweep(vecs[i], (i == 2), 1'b0);

        // Host write then read in DONE
        load_mem(vecs[0]);
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd5; host_din = 16'hBEEF;
        #1;
        chk("host_gnt_write", host_gnt, 1);
        chk("mem_we_host", mem_we, 1);
        @(negedge clk);
        chk("host_rvalid_after_write", host_rvalid, 0);
        host_we = 1'b0;
        #1;
        chk("host_gnt_read", host_gnt, 1);
        if (host_gnt) host_sb.push_back(16'hBEEF);
        @(negedge clk);
        host_req = 1'b0;
        chk("host_rvalid", host_rvalid, 1);
        if (host_rvalid && host_sb.size() != 0) begin
            hx = host_sb.pop_front();
            chk("host_rdata", host_rdata, hx);
        end
        @(negedge clk);
        chk("host_rvalid_single", host_rvalid, 0);

        // Reset at the fifth read cycle aborts the sweep
        load_mem(vecs[2]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = sw_start ? 1 : 0;
        for (int k = 0; k < 40 && cyc < 13; k++) begin
            @(negedge clk);
            if (sw_start) cyc++;
        end
        chk("abort_point_reached", cyc, 13);
        chk("cnt_high_before_abort", cnt_high, 3);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        rst = 1'b0;
        run_sweep(vecs[2], 1'b0, 1'b0);

        // start held high: one-cycle DONE, back-to-back identical sweeps
        load_mem(vecs[1]);
        sb.push_back(vecs[1]);
        sb.push_back(vecs[1]);
        start = 1'b1;
        wait_done(0, 1'b0, cyc, ok);
        chk("b2b_done1", ok, 1);
        chk("b2b_cycles1", cyc, 16);
        check_results(1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_one_cycle", done, 0);
        chk("b2b_relaunch", sw_start, 1);
        chk("b2b_cleared", {cnt_high, cnt_both, log_count, log_ovf}, 0);
        wait_done(1, 1'b0, cyc, ok);
        chk("b2b_done2", ok, 1);
        chk("b2b_cycles2", cyc, 16);
        check_results(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
